adt7420_i2c_target: RTL

Synchronous I2C target (responder) that emulates the ADT7420 temperature sensor's register map on SCL/SDA. It is the far end of the team's I2C master driver. In simulation it serves as the bus-functional sensor model. On hardware it can be instantiated as a loopback target on a spare I2C pair, fed by local logic. The master sees 16 byte registers with ADT7420 reset values, pointer-based access, auto-increment and open-drain SDA.

---
 rtl/adt7420_i2c_target.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/adt7420_i2c_target.sv
// I2C target emulating the ADT7420 register map (16 byte registers, pointer access, auto-increment).
// Define I2C_TGT_GLITCH_FILTER_EN to insert a 3-sample majority filter on the synchronized SCL/SDA.
module adt7420_i2c_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h48,
  parameter logic [7:0] ID_VALUE   = 8'hCB
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic        temp_wr,
  input  logic [15:0] temp_val,
  output logic        busy,
  output logic        wr_strobe,
  output logic [3:0]  wr_addr,
  output logic [7:0]  wr_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_l, sda_l, scl_prev_q, sda_prev_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        flag_q, flag_d;
  logic        rw_q, rw_d;
  logic        strobe_q, strobe_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [15:0] temp_q;
  logic [7:0]  cfg_q [8];
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [7:0]  rd_byte, rx_byte;
  logic        scl_rise, scl_fall, start_det, stop_det, last_bit, writable;

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_q <= (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) |
                    (scl_hist_q[0] & scl_hist_q[1]);
      sda_filt_q <= (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) |
                    (sda_hist_q[0] & sda_hist_q[1]);
    end
  end

  assign scl_l = scl_filt_q;
  assign sda_l = sda_filt_q;
`else
  assign scl_l = scl_sync_q[1];
  assign sda_l = sda_sync_q[1];
`endif

  assign scl_rise  = scl_l & ~scl_prev_q;
  assign scl_fall  = ~scl_l & scl_prev_q;
  assign start_det = scl_l & scl_prev_q & sda_prev_q & ~sda_l;
  assign stop_det  = scl_l & scl_prev_q & ~sda_prev_q & sda_l;
  assign rx_byte   = {shift_q, sda_l};
  assign last_bit  = (bit_cnt_q == 3'd7);
  assign cfg_idx   = 3'(ptr_q - 4'd3);
  assign writable  = (ptr_q >= 4'd3) && (ptr_q <= 4'd10);

  always_comb begin
    rd_byte = 8'h00;
    case (ptr_q)
      4'h0: rd_byte = temp_q[15:8];
      4'h1: rd_byte = temp_q[7:0];
      4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: rd_byte = cfg_q[cfg_idx];
      4'hB: rd_byte = ID_VALUE;
      default: rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    flag_d    = flag_q;
    rw_d      = rw_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cfg_we    = 1'b0;
    if (stop_det) begin
      state_d   = S_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 3'd0;
      flag_d    = 1'b0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 3'd0;
      flag_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              if (state_q == S_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = S_ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = S_IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == S_PTR) begin
                ptr_d   = rx_byte[3:0];
                state_d = S_PTR_ACK;
              end else begin
                if (writable) begin
                  cfg_we    = 1'b1;
                  strobe_d  = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = rx_byte;
                end
                ptr_d   = ptr_q + 4'd1;
                state_d = S_WDATA_ACK;
              end
            end
          end
        end
        // flag_q marks that the ACK is already being driven
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!flag_q) begin
              sda_oe_d = 1'b1;
              flag_d   = 1'b1;
            end else begin
              flag_d    = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                shift_d  = rd_byte[6:0];
                sda_oe_d = ~rd_byte[7];
                state_d  = S_RDATA;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = (state_q == S_ADDR_ACK) ? S_PTR : S_WDATA;
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            if (last_bit) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = S_RDATA_ACK;
            end else begin
              sda_oe_d  = ~shift_q[6];
              shift_d   = {shift_q[5:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        // flag_q here records a master ACK awaiting the next byte load
        S_RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_l) begin
              ptr_d  = ptr_q + 4'd1;
              flag_d = 1'b1;
            end else begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && flag_q) begin
            flag_d    = 1'b0;
            shift_d   = rd_byte[6:0];
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = 3'd0;
            state_d   = S_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      ptr_q      <= 4'd0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      flag_q     <= 1'b0;
      rw_q       <= 1'b0;
      strobe_q   <= 1'b0;
      wr_addr_q  <= 4'd0;
      wr_data_q  <= 8'd0;
      temp_q     <= 16'd0;
      cfg_q[0]   <= 8'h00;
      cfg_q[1]   <= 8'h20;
      cfg_q[2]   <= 8'h00;
      cfg_q[3]   <= 8'h05;
      cfg_q[4]   <= 8'h00;
      cfg_q[5]   <= 8'h49;
      cfg_q[6]   <= 8'h80;
      cfg_q[7]   <= 8'h05;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_l;
      sda_prev_q <= sda_l;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      flag_q     <= flag_d;
      rw_q       <= rw_d;
      strobe_q   <= strobe_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      if (temp_wr) temp_q <= temp_val;
      if (cfg_we) cfg_q[cfg_idx] <= rx_byte;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule
